pcu: RTL and testbench

PCU -- requirements
Module: pcu

---
 rtl/pcu.sv | 107 ++++++++++
 tb/tb_pcu.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcu.sv
// Program counter unit: a boot/run/halt FSM that sequences fetch addresses and applies
// trap, mret and redirect control events, with misaligned-target diversion to mtvec.
module pcu #(
   parameter int unsigned                CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0]       RESET_VEC = 32'h8000_0000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_fetch_rdy,
   input  logic                 i_stall,
   input  logic                 i_redir_vld,
   input  logic [CPU_WIDTH-1:0] i_redir_pc,
   input  logic                 i_trap_vld,
   input  logic [CPU_WIDTH-1:0] i_mtvec,
   input  logic                 i_mret_vld,
   input  logic [CPU_WIDTH-1:0] i_mepc,
   input  logic                 i_halt,
   output logic [CPU_WIDTH-1:0] o_pc,
   output logic                 o_pc_vld,
   output logic                 o_misalign,
   output logic [CPU_WIDTH-1:0] o_bad_addr,
   output logic                 o_halted,
   output logic [31:0]          o_fetch_cnt
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

   state_e                 state_q, state_d;
   logic [CPU_WIDTH-1:0]   pc_q, pc_d;
   logic                   misalign_q, misalign_d;
   logic [CPU_WIDTH-1:0]   bad_addr_q, bad_addr_d;
   logic [31:0]            cnt_q, cnt_d;

   logic                   handshake;
   logic [CPU_WIDTH-1:0]   mtvec_al;

   // The trap vector is silently word-aligned; it never raises a misalign report.
   assign mtvec_al  = i_mtvec & ~{{(CPU_WIDTH-2){1'b0}}, 2'b11};
   assign handshake = (state_q == StRun) & i_fetch_rdy & ~i_stall;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = 1'b0;
      bad_addr_d = bad_addr_q;
      cnt_d      = cnt_q;
      unique case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (i_halt) begin
               state_d = StHalt;
            end else begin
               if (handshake) begin
                  cnt_d = cnt_q + 32'd1;
               end
               if (i_trap_vld) begin
                  pc_d = mtvec_al;
               end else if (i_mret_vld) begin
                  if (i_mepc[1:0] != 2'b00) begin
                     pc_d       = mtvec_al;
                     misalign_d = 1'b1;
                     bad_addr_d = i_mepc;
                  end else begin
                     pc_d = i_mepc;
                  end
               end else if (i_redir_vld) begin
                  if (i_redir_pc[1:0] != 2'b00) begin
                     pc_d       = mtvec_al;
                     misalign_d = 1'b1;
                     bad_addr_d = i_redir_pc;
                  end else begin
                     pc_d = i_redir_pc;
                  end
               end else if (handshake) begin
                  pc_d = pc_q + CPU_WIDTH'(4);
               end
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StBoot;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StBoot;
         pc_q       <= RESET_VEC;
         misalign_q <= 1'b0;
         bad_addr_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
         bad_addr_q <= bad_addr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_pc        = pc_q;
   assign o_pc_vld    = (state_q == StRun);
   assign o_misalign  = misalign_q;
   assign o_bad_addr  = bad_addr_q;
   assign o_halted    = (state_q == StHalt);
   assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pcu.sv
// Directed bench for pcu: sequential fetch, stall, event priority, misalign, wrap, halt, reset.
module tb_pcu;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_fetch_rdy;
   logic        i_stall;
   logic        i_redir_vld;
   logic [31:0] i_redir_pc;
   logic        i_trap_vld;
   logic [31:0] i_mtvec;
   logic        i_mret_vld;
   logic [31:0] i_mepc;
   logic        i_halt;
   logic [31:0] o_pc;
   logic        o_pc_vld;
   logic        o_misalign;
   logic [31:0] o_bad_addr;
   logic        o_halted;
   logic [31:0] o_fetch_cnt;

   int checks;
   int failures;

   pcu #(
      .CPU_WIDTH (32),
      .RESET_VEC (32'h8000_0000)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_fetch_rdy (i_fetch_rdy),
      .i_stall     (i_stall),
      .i_redir_vld (i_redir_vld),
      .i_redir_pc  (i_redir_pc),
      .i_trap_vld  (i_trap_vld),
      .i_mtvec     (i_mtvec),
      .i_mret_vld  (i_mret_vld),
      .i_mepc      (i_mepc),
      .i_halt      (i_halt),
      .o_pc        (o_pc),
      .o_pc_vld    (o_pc_vld),
      .o_misalign  (o_misalign),
      .o_bad_addr  (o_bad_addr),
      .o_halted    (o_halted),
      .o_fetch_cnt (o_fetch_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear_events();
      i_redir_vld = 1'b0;
      i_trap_vld  = 1'b0;
      i_mret_vld  = 1'b0;
      i_halt      = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      #1;
      checks++;
      if (o_pc !== 32'h8000_0000 || o_pc_vld !== 1'b0 || o_misalign !== 1'b0 ||
          o_bad_addr !== 32'h0 || o_halted !== 1'b0 || o_fetch_cnt !== 32'h0) begin
         failures++;
         $display("FAIL reset_values pc=%h vld=%b mis=%b bad=%h halt=%b cnt=%0d", o_pc, o_pc_vld,
                  o_misalign, o_bad_addr, o_halted, o_fetch_cnt);
      end
      tick();
      i_rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      i_fetch_rdy = 1'b1;
      checks++;
      if (o_pc !== 32'h8000_0000 || o_pc_vld !== 1'b0) begin
         failures++;
         $display("FAIL boot pc=%h vld=%b expected 80000000 vld=0", o_pc, o_pc_vld);
      end
      tick();
      checks++;
      if (o_pc !== 32'h8000_0000 || o_pc_vld !== 1'b1 || o_fetch_cnt !== 32'd0) begin
         failures++;
         $display("FAIL run_first pc=%h vld=%b cnt=%0d expected 80000000 1 0", o_pc, o_pc_vld,
                  o_fetch_cnt);
      end
      tick();
      checks++;
      if (o_pc !== 32'h8000_0004 || o_fetch_cnt !== 32'd1) begin
         failures++;
         $display("FAIL seq_4 pc=%h cnt=%0d expected 80000004 1", o_pc, o_fetch_cnt);
      end
      tick();
      checks++;
      if (o_pc !== 32'h8000_0008 || o_fetch_cnt !== 32'd2) begin
         failures++;
         $display("FAIL seq_8 pc=%h cnt=%0d expected 80000008 2", o_pc, o_fetch_cnt);
      end
      tick();
      checks++;
      if (o_pc !== 32'h8000_000C || o_fetch_cnt !== 32'd3) begin
         failures++;
         $display("FAIL seq_c pc=%h cnt=%0d expected 8000000c 3", o_pc, o_fetch_cnt);
      end
      i_fetch_rdy = 1'b0;
      tick();
      checks++;
      if (o_pc !== 32'h8000_000C || o_fetch_cnt !== 32'd3) begin
         failures++;
         $display("FAIL not_ready_hold pc=%h cnt=%0d expected 8000000c 3", o_pc, o_fetch_cnt);
      end
   endtask

   task automatic test_stall();
      i_fetch_rdy = 1'b1;
      tick();
      i_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (o_pc !== 32'h8000_0010 || o_fetch_cnt !== 32'd4) begin
            failures++;
            $display("FAIL stall_hold[%0d] pc=%h cnt=%0d expected 80000010 4", i, o_pc,
                     o_fetch_cnt);
         end
      end
      i_redir_vld = 1'b1;
      i_redir_pc  = 32'h8000_0100;
      tick();
      clear_events();
      i_stall     = 1'b0;
      i_fetch_rdy = 1'b0;
      checks++;
      if (o_pc !== 32'h8000_0100 || o_fetch_cnt !== 32'd4) begin
         failures++;
         $display("FAIL stall_redirect pc=%h cnt=%0d expected 80000100 4", o_pc, o_fetch_cnt);
      end
   endtask

   task automatic test_priority();
      i_trap_vld  = 1'b1;
      i_mtvec     = 32'h8000_0200;
      i_mret_vld  = 1'b1;
      i_mepc      = 32'h8000_0300;
      i_redir_vld = 1'b1;
      i_redir_pc  = 32'h8000_0400;
      tick();
      checks++;
      if (o_pc !== 32'h8000_0200 || o_misalign !== 1'b0) begin
         failures++;
         $display("FAIL prio_trap pc=%h mis=%b expected 80000200 0", o_pc, o_misalign);
      end
      i_trap_vld = 1'b0;
      tick();
      checks++;
      if (o_pc !== 32'h8000_0300) begin
         failures++;
         $display("FAIL prio_mret pc=%h expected 80000300", o_pc);
      end
      i_mret_vld = 1'b0;
      tick();
      clear_events();
      checks++;
      if (o_pc !== 32'h8000_0400) begin
         failures++;
         $display("FAIL redirect_only pc=%h expected 80000400", o_pc);
      end
   endtask

   task automatic test_misalign();
      i_mtvec     = 32'h8000_0200;
      i_redir_vld = 1'b1;
      i_redir_pc  = 32'h8000_0102;
      tick();
      clear_events();
      checks++;
      if (o_pc !== 32'h8000_0200 || o_misalign !== 1'b1 || o_bad_addr !== 32'h8000_0102) begin
         failures++;
         $display("FAIL redir_misalign pc=%h mis=%b bad=%h expected 80000200 1 80000102", o_pc,
                  o_misalign, o_bad_addr);
      end
      tick();
      checks++;
      if (o_pc !== 32'h8000_0200 || o_misalign !== 1'b0 || o_bad_addr !== 32'h8000_0102) begin
         failures++;
         $display("FAIL misalign_pulse pc=%h mis=%b bad=%h expected 80000200 0 80000102", o_pc,
                  o_misalign, o_bad_addr);
      end
      i_mret_vld = 1'b1;
      i_mepc     = 32'h8000_0301;
      tick();
      clear_events();
      checks++;
      if (o_pc !== 32'h8000_0200 || o_misalign !== 1'b1 || o_bad_addr !== 32'h8000_0301) begin
         failures++;
         $display("FAIL mret_misalign pc=%h mis=%b bad=%h expected 80000200 1 80000301", o_pc,
                  o_misalign, o_bad_addr);
      end
      i_trap_vld = 1'b1;
      i_mtvec    = 32'h8000_0503;
      tick();
      clear_events();
      checks++;
      if (o_pc !== 32'h8000_0500 || o_misalign !== 1'b0 || o_bad_addr !== 32'h8000_0301) begin
         failures++;
         $display("FAIL mtvec_align pc=%h mis=%b bad=%h expected 80000500 0 80000301", o_pc,
                  o_misalign, o_bad_addr);
      end
   endtask

   task automatic test_wrap();
      // Redirect plus handshake in the same cycle still counts the fetch.
      i_fetch_rdy = 1'b1;
      i_redir_vld = 1'b1;
      i_redir_pc  = 32'hFFFF_FFFC;
      tick();
      clear_events();
      checks++;
      if (o_pc !== 32'hFFFF_FFFC || o_fetch_cnt !== 32'd5) begin
         failures++;
         $display("FAIL wrap_redirect pc=%h cnt=%0d expected fffffffc 5", o_pc, o_fetch_cnt);
      end
      tick();
      i_fetch_rdy = 1'b0;
      checks++;
      if (o_pc !== 32'h0000_0000 || o_fetch_cnt !== 32'd6 || o_misalign !== 1'b0) begin
         failures++;
         $display("FAIL wrap_pc pc=%h cnt=%0d mis=%b expected 00000000 6 0", o_pc, o_fetch_cnt,
                  o_misalign);
      end
   endtask

   task automatic test_halt();
      i_halt      = 1'b1;
      i_redir_vld = 1'b1;
      i_redir_pc  = 32'h8000_0700;
      i_fetch_rdy = 1'b1;
      tick();
      checks++;
      if (o_pc !== 32'h0 || o_pc_vld !== 1'b0 || o_halted !== 1'b1 || o_fetch_cnt !== 32'd6) begin
         failures++;
         $display("FAIL halt_entry pc=%h vld=%b halt=%b cnt=%0d expected 0 0 1 6", o_pc, o_pc_vld,
                  o_halted, o_fetch_cnt);
      end
      i_halt     = 1'b0;
      i_trap_vld = 1'b1;
      tick();
      tick();
      checks++;
      if (o_pc !== 32'h0 || o_halted !== 1'b1 || o_fetch_cnt !== 32'd6) begin
         failures++;
         $display("FAIL halt_ignore pc=%h halt=%b cnt=%0d expected 0 1 6", o_pc, o_halted,
                  o_fetch_cnt);
      end
      clear_events();
      #2;
      i_rst_n = 1'b0;
      #1;
      checks++;
      if (o_pc !== 32'h8000_0000 || o_pc_vld !== 1'b0 || o_misalign !== 1'b0 ||
          o_bad_addr !== 32'h0 || o_halted !== 1'b0 || o_fetch_cnt !== 32'h0) begin
         failures++;
         $display("FAIL halt_async_reset pc=%h vld=%b mis=%b bad=%h halt=%b cnt=%0d", o_pc,
                  o_pc_vld, o_misalign, o_bad_addr, o_halted, o_fetch_cnt);
      end
      tick();
      i_rst_n = 1'b1;
      checks++;
      if (o_pc_vld !== 1'b0) begin
         failures++;
         $display("FAIL reboot_boot vld=%b expected 0", o_pc_vld);
      end
      tick();
      checks++;
      if (o_pc !== 32'h8000_0000 || o_pc_vld !== 1'b1 || o_halted !== 1'b0) begin
         failures++;
         $display("FAIL reboot_run pc=%h vld=%b halt=%b expected 80000000 1 0", o_pc, o_pc_vld,
                  o_halted);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      i_rst_n     = 1'b1;
      i_fetch_rdy = 1'b0;
      i_stall     = 1'b0;
      i_redir_pc  = '0;
      i_mtvec     = 32'h8000_0200;
      i_mepc      = '0;
      clear_events();
      #2;
      test_reset();
      test_sequential();
      test_stall();
      test_priority();
      test_misalign();
      test_wrap();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
